// File: rtl/seq_addsub.sv
// Digit-serial two's-complement adder/subtractor with registered flags.
// Optional macro SEQ_ADDSUB_SAT_EN: saturate s on signed overflow.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_chk
    $error("seq_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             op_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             v_q;
  logic             z_q;
  logic             n_q;

  logic             go;
  logic             last;
  logic [DIGIT:0]   sum_w;
  logic             cout;
  logic             cin_msb;
  logic             v_nx;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] s_fin;

  assign go   = (state_q == IDLE) && start;
  assign last = (cnt == CW'(K - 1));

  // Shared DIGIT-bit slice; carry into its top bit is the MSB carry-in
  assign sum_w = {1'b0, a_q[DIGIT-1:0]}
               + {1'b0, b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, cy};
  assign cout    = sum_w[DIGIT];
  assign cin_msb = sum_w[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign v_nx    = cin_msb ^ cout;

  if (DIGIT == WIDTH) begin : g_one
    assign res_nx = sum_w[DIGIT-1:0];
  end else begin : g_shift
    assign res_nx = {sum_w[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
  end

`ifdef SEQ_ADDSUB_SAT_EN
  // Wrapped sign is opposite the true sign on overflow
  assign s_fin = v_nx ? {~res_nx[WIDTH-1], {(WIDTH-1){res_nx[WIDTH-1]}}}
                      : res_nx;
`else
  assign s_fin = res_nx;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    s    = s_q;
    c    = c_q;
    v    = v_q;
    z    = z_q;
    n    = n_q;
  end

  // Operand shifters, carry chain and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      op_q   <= 1'b0;
      done_q <= 1'b0;
      s_q    <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        a_q  <= a;
        b_q  <= b ^ {WIDTH{op}};
        cy   <= op;
        op_q <= op;
        cnt  <= '0;
      end else if (state_q == RUN) begin
        acc <= res_nx;
        a_q <= a_q >> DIGIT;
        b_q <= b_q >> DIGIT;
        cy  <= cout;
        cnt <= cnt + 1'b1;
        if (last) begin
          s_q    <= s_fin;
          c_q    <= cout ^ op_q;
          v_q    <= v_nx;
          z_q    <= (s_fin == '0);
          n_q    <= s_fin[WIDTH-1];
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub.
// Covers 8x1 and 16x4 configurations.
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done, c, v, z, n;
  logic [7:0]  s;

  logic        start2 = 1'b0;
  logic        op2 = 1'b0;
  logic [15:0] a2 = '0;
  logic [15:0] b2 = '0;
  logic        busy2, done2, c2, v2, z2, n2;
  logic [15:0] s2;

  int errors = 0;
  int checks = 0;
  int cyc;
  int bcnt;
  logic saw;

  seq_addsub #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .s(s), .c(c), .v(v), .z(z), .n(n)
  );

  seq_addsub #(.WIDTH(16), .DIGIT(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op2),
    .a(a2), .b(b2), .busy(busy2), .done(done2),
    .s(s2), .c(c2), .v(v2), .z(z2), .n(n2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go8(input logic [7:0] aa, input logic [7:0] bb,
                     input logic o);
    @(negedge clk);
    start = 1'b1; a = aa; b = bb; op = o;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait8();
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic flags(input string tag, input logic [7:0] es,
                       input logic ec, input logic ev,
                       input logic ez, input logic en);
    chk({tag, "_s"}, 32'(s), 32'(es));
    chk({tag, "_c"}, 32'(c), 32'(ec));
    chk({tag, "_v"}, 32'(v), 32'(ev));
    chk({tag, "_z"}, 32'(z), 32'(ez));
    chk({tag, "_n"}, 32'(n), 32'(en));
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s", 32'(s), 0);
    chk("rst_czvn", 32'({c, v, z, n}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    go8(8'h05, 8'h03, 1'b0);
    chk("t1_busy0", 32'(busy), 1);
    wait8();
    chk("t1_lat", cyc, 8);
    chk("t1_bcnt", bcnt, 8);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy", 32'(busy), 0);
    flags("t1", 8'h08, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk("t1_dclr", 32'(done), 0);

    go8(8'h7F, 8'h01, 1'b0);
    wait8();
`ifdef SEQ_ADDSUB_SAT_EN
    flags("t2", 8'h7F, 0, 1, 0, 0);
`else
    flags("t2", 8'h80, 0, 1, 0, 1);
`endif

    go8(8'h03, 8'h05, 1'b1);
    wait8();
    flags("t3", 8'hFE, 1, 0, 0, 1);

    go8(8'h05, 8'h05, 1'b1);
    wait8();
    flags("t4", 8'h00, 0, 0, 1, 0);

    go8(8'h80, 8'h01, 1'b1);
    wait8();
`ifdef SEQ_ADDSUB_SAT_EN
    flags("t5", 8'h80, 0, 1, 0, 1);
`else
    flags("t5", 8'h7F, 0, 1, 0, 0);
`endif

    go8(8'h10, 8'h20, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h66; op = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait8();
    chk("t6_done", 32'(done), 1);
    flags("t6", 8'h30, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; op = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t7_busy", 32'(busy), 1);
    chk("t7_dclr", 32'(done), 0);
    wait8();
    chk("t7_lat", cyc, 8);
    flags("t7", 8'h02, 0, 0, 0, 0);

    go8(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_busy", 32'(busy), 0);
    chk("t8_done", 32'(done), 0);
    chk("t8_s", 32'(s), 0);
    chk("t8_czvn", 32'({c, v, z, n}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 if (done || busy) saw = 1'b1;
    end
    chk("t8_nodone", 32'(saw), 0);

    @(negedge clk);
    start2 = 1'b1; a2 = 16'h7FFF; b2 = 16'h0001; op2 = 1'b0;
    @(posedge clk);
    #1 start2 = 1'b0;
    cyc = 0;
    bcnt = 0;
    while (!done2 && cyc < 40) begin
      if (busy2) bcnt++;
      @(posedge clk);
      #1 cyc++;
    end
    chk("w_lat", cyc, 4);
    chk("w_bcnt", bcnt, 4);
`ifdef SEQ_ADDSUB_SAT_EN
    chk("w_s", 32'(s2), 32'h7FFF);
`else
    chk("w_s", 32'(s2), 32'h8000);
`endif
    chk("w_v", 32'(v2), 1);
    chk("w_c", 32'(c2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor: next generation of the fixed-width ripple add/sub datapath.
- Processes DIGIT bits per clock over WIDTH-bit operands using one shared DIGIT-bit full-adder slice.
- Start/busy/done handshake; registered result and status flags (carry/borrow, overflow, zero, negative).
- Sits between the operand registers and the flag/result bus of the lab ALU.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- DIGIT, 1, bits processed per cycle; WIDTH must be a multiple of DIGIT. Violation is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = A+B, 1 = A-B; sampled with start.
- a  in  WIDTH  minuend/augend; sampled with start.
- b  in  WIDTH  subtrahend/addend; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when results update.
- s  out  WIDTH  sum/difference, registered.
- c  out  1  carry (add) or borrow (sub), registered.
- v  out  1  signed overflow, registered.
- z  out  1  s == 0, registered.
- n  out  1  s[WIDTH-1], registered.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, s, c, v, z, n all 0; internal shift registers and counter cleared. Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN. K = WIDTH/DIGIT.
- IDLE with start=1 at edge T0:
  - Latch a.
  - Latch b XOR {WIDTH{op}}.
  - carry <- op.
  - op_q <- op.
  - cnt <- 0.
  - busy <- 1.
  - Go to RUN.
- RUN, each edge:
  - Add the low DIGIT bits of the latched operands plus carry.
  - Shift the result digit into the result register from the MSB side; shift the operands right by DIGIT.
  - carry <- slice carry-out.
  - Record the carry into the MSB position (c_in_msb) when processing the top digit.
  - cnt++.
- On edge TK (the Kth RUN edge):
  - s <- completed result.
  - c <- carry_out XOR op_q (borrow = NOT carry for subtraction).
  - v <- c_in_msb XOR carry_out.
  - z, n computed from the final s.
  - done <- 1, busy <- 0, state <- IDLE.
- Latency: busy high for exactly K cycles (T0..TK); done high for the single cycle following TK.
- done clears on the next edge unless a new completion occurs.
- start while busy=1 is ignored: it is not queued, and the latched operands are unaffected.
- Back-to-back: start asserted during the done cycle is accepted (state is IDLE). done still drops after one cycle.
- Outputs s/c/v/z/n hold their last values until the next completion. a/b/op changes during RUN have no effect.
- Arithmetic is modulo 2^WIDTH; no width extension of s.

Optional Feature:
- Macro: SEQ_ADDSUB_SAT_EN
- Defined: when overflow is detected at completion, s saturates instead of wrapping.
  - Positive overflow (true result > max): s <- 2^(WIDTH-1)-1.
  - Negative overflow: s <- 2^(WIDTH-1).
  - v still reports 1.
  - c reflects the raw carry/borrow.
  - z and n are computed from the saturated s.
- Undefined: wrap-around result; no saturation logic is synthesised.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x05, b=0x03, op=0 -> done exactly 1 cycle after the 8th edge following start; s=0x08, c=0, v=0, z=0, n=0; busy high for 8 cycles.
- a=0x7F, b=0x01, op=0 -> s=0x80, c=0, v=1, n=1. With SEQ_ADDSUB_SAT_EN: s=0x7F, v=1, n=0.
- a=0x03, b=0x05, op=1 -> s=0xFE, c=1 (borrow), v=0, n=1. a=0x05, b=0x05, op=1 -> s=0x00, z=1, c=0.
- a=0x80, b=0x01, op=1 -> s=0x7F, v=1, c=0. With SEQ_ADDSUB_SAT_EN: s=0x80, n=1.
- Second start pulsed at cycle 3 of RUN with different operands -> ignored; the first result is reported. Start asserted during the done cycle -> new operation accepted, busy=1 next cycle.
- rst_n pulled low at cycle 4 of RUN -> all outputs 0 immediately, no done. Separately, WIDTH=16, DIGIT=4: 0x7FFF+0x0001 -> busy 4 cycles, s=0x8000, v=1.
